// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Front-end fetch stage. Owns the PC, issues in-order word reads
//               to instruction memory over a valid/ready port, buffers the
//               returned words in a small FIFO and hands {bits, pc} to decode.
//               Redirects flush the FIFO and drop responses still in flight.
// Ports       : clk, rst_n (sync, active low)
//               imem_req_valid/ready/addr   - memory read request
//               imem_resp_valid/data        - in-order responses, no backpressure
//               redirect_valid/pc           - restart fetch at a new PC
//               instr_valid/ready/bits/pc   - decoded-side handshake
//               instr_fault                 - head entry is a fetch fault
// Options     : FETCH_MISALIGN_TRAP_EN - a misaligned redirect target produces
//               one fault entry instead of fetching; otherwise the low two
//               bits of the target are cleared and instr_fault is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     ILEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr_bits,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_fault
);

  localparam int unsigned    PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned    CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [2:0] S_FAULT = 3'd3;  // push the fault entry this cycle
  localparam logic [2:0] S_STALL = 3'd4;  // wait for the next redirect
`endif

  logic [2:0]       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;

  logic [ILEN-1:0]  fifo_bits_q [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_pc_q   [FIFO_DEPTH];

  logic             w_req_fire;
  logic             w_pop;
  logic             w_resp;
  logic             w_resp_keep;
  logic             w_push;
  logic [ILEN-1:0]  w_push_bits;
  logic [XLEN-1:0]  w_push_pc;
  logic [XLEN-1:0]  w_redir_pc;
  logic [CNT_W:0]   w_credit;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic             fifo_fault_q [FIFO_DEPTH];
  logic             fault_pending_q;
  logic [XLEN-1:0]  fault_pc_q;
  logic             w_push_fault;
  logic             w_misalign;
  assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  logic             w_unused_lsbs;
  assign w_unused_lsbs = ^redirect_pc[1:0];
`endif

  assign w_req_fire  = imem_req_valid && imem_req_ready;
  assign w_pop       = instr_valid && instr_ready;
  // A response with nothing outstanding can only be a leftover from before
  // reset; it is neither counted nor buffered.
  assign w_resp      = imem_resp_valid && (outst_q != '0);
  assign w_resp_keep = w_resp && (discard_q == '0);
  assign w_redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_credit    = {1'b0, outst_q} + {1'b0, count_q};

  // FIFO write source: a memory response, or the synthetic fault entry.
  // Nothing is written in a redirect cycle since the FIFO is being flushed.
  always_comb begin
    w_push      = 1'b0;
    w_push_bits = imem_resp_data;
    w_push_pc   = resp_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_push_fault = 1'b0;
`endif
    if (!redirect_valid) begin
      w_push = w_resp_keep;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (state_q == S_FAULT) begin
        w_push       = 1'b1;
        w_push_bits  = ILEN'(32'h0000_0013);
        w_push_pc    = fault_pc_q;
        w_push_fault = 1'b1;
      end
`endif
    end
  end

  // Datapath next-state. A redirect overrides everything else, and the
  // discard count includes any request accepted in the redirect cycle.
  always_comb begin
    outst_d   = outst_q + CNT_W'(w_req_fire) - CNT_W'(w_resp);
    discard_d = discard_q;
    if (w_resp && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end
    pc_d = pc_q;
    if (w_req_fire) begin
      pc_d = pc_q + XLEN'(4);
    end
    // resp_pc follows the oldest request whose response will be kept.
    resp_pc_d = resp_pc_q;
    if (w_resp_keep) begin
      resp_pc_d = resp_pc_q + XLEN'(4);
    end
    count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    wptr_d  = w_push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = w_pop  ? rptr_q + PTR_W'(1) : rptr_q;
    if (redirect_valid) begin
      discard_d = outst_d;
      pc_d      = w_redir_pc;
      resp_pc_d = w_redir_pc;
      count_d   = '0;
      wptr_d    = '0;
      rptr_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_pending_q <= 1'b0;
      fault_pc_q      <= '0;
`endif
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_valid) begin
        fault_pending_q <= w_misalign;
        fault_pc_q      <= redirect_pc;
      end
`endif
    end
  end

  // Storage needs no reset: the outputs are gated by instr_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_bits_q[wptr_q] <= w_push_bits;
      fifo_pc_q[wptr_q]   <= w_push_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
      fifo_fault_q[wptr_q] <= w_push_fault;
`endif
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_FETCH;
      S_DRAIN: begin
        if (discard_d == '0) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          state_d = fault_pending_q ? S_FAULT : S_FETCH;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_FAULT: state_d = S_STALL;
      S_STALL: state_d = S_STALL;
`endif
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) begin
      if (discard_d != '0) begin
        state_d = S_DRAIN;
      end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
        state_d = w_misalign ? S_FAULT : S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end
    end
  end

  // FSM: outputs. The credit term only grows on a handshake, so a raised
  // request stays raised with a stable address until accepted or redirected.
  always_comb begin
    imem_req_valid = (state_q == S_FETCH) && (w_credit < DEPTH_C);
    imem_req_addr  = pc_q;
  end

  assign instr_valid = (count_q != '0);
  assign instr_bits  = instr_valid ? fifo_bits_q[rptr_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[rptr_q]   : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign instr_fault = instr_valid && fifo_fault_q[rptr_q];
`else
  assign instr_fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Randomized bench for instruction_fetch with an in-order
//               memory model and a scoreboard of expected decode entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_bits;
  logic [31:0] instr_pc;
  logic        instr_fault;

  always #5 clk = ~clk;

  instruction_fetch #(
    .XLEN       (32),
    .ILEN       (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_bits      (instr_bits),
    .instr_pc        (instr_pc),
    .instr_fault     (instr_fault)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] bits; logic fault; } exp_t;
  typedef struct packed { logic [31:0] addr; int due; } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  exp_t        head;
  int          n_vec = 0, n_err = 0, cyc = 0, rst_edges = 0, hs_count = 0;
  int          lat_max = 1, p_ready = 100, p_iready = 100, p_redir = 0;
  bit          force_redir = 0;
  logic [31:0] force_pc = '0;
  logic [31:0] model_pc = RST_PC;
  bit          model_stall = 0;
  bit          pend = 0, last_redir = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    case ($urandom_range(3))
      0:       t = 32'hFFFF_FFF0 | (t & 32'h0000_000C);
      1:       t = t & 32'h0000_0FFF;
      default: ;
    endcase
    if ($urandom_range(3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  always @(posedge clk) rst_edges <= rst_n ? 0 : rst_edges + 1;

  // Monitor: compares every consumed entry against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (rst_edges > 0) begin
        check("reset_req_valid",   {31'b0, imem_req_valid}, 32'd0);
        check("reset_instr_valid", {31'b0, instr_valid},    32'd0);
        check("reset_instr_fault", {31'b0, instr_fault},    32'd0);
        check("reset_instr_bits",  instr_bits,              32'd0);
        check("reset_instr_pc",    instr_pc,                32'd0);
      end
    end else if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_instr", $sformatf("got pc 0x%08h, expected nothing", instr_pc));
      end else begin
        head = exp_q.pop_front();
        check("instr_pc",    instr_pc,               head.pc);
        check("instr_bits",  instr_bits,             head.bits);
        check("instr_fault", {31'b0, instr_fault},   {31'b0, head.fault});
      end
    end
  end

  task automatic step_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_mem();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  endtask

  // Reference model: every request accepted since the last redirect is
  // delivered once, in order, with the word stored at its address.
  task automatic observe();
    mreq_t m;
    exp_t  e;
    if (!rst_n) begin
      pend = 0;
      last_redir = 0;
      return;
    end
    if (last_redir) check("flush_empty", {31'b0, instr_valid}, 32'd0);
    if (pend) begin
      check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
      check("req_hold_addr",  imem_req_addr, pend_addr);
    end
    if (imem_req_valid && imem_req_ready) begin
      hs_count++;
      if (model_stall) fail("req_while_stalled", $sformatf("request 0x%08h", imem_req_addr));
      check("req_addr", imem_req_addr, model_pc);
      m.addr = imem_req_addr;
      m.due  = cyc + 1 + int'($urandom_range(lat_max - 1));
      mem_q.push_back(m);
      e.pc    = model_pc;
      e.bits  = mem_word(model_pc);
      e.fault = 1'b0;
      exp_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
    pend       = imem_req_valid && !imem_req_ready && !redirect_valid;
    pend_addr  = imem_req_addr;
    last_redir = redirect_valid;
    if (redirect_valid) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        e.pc    = redirect_pc;
        e.bits  = 32'h0000_0013;
        e.fault = 1'b1;
        exp_q.push_back(e);
        model_stall = 1;
      end else begin
        model_stall = 0;
        model_pc    = {redirect_pc[31:2], 2'b00};
      end
`else
      model_pc = {redirect_pc[31:2], 2'b00};
`endif
    end
  endtask

  task automatic cycle();
    step_edge();
    imem_req_ready = ($urandom_range(99) < p_ready);
    instr_ready    = ($urandom_range(99) < p_iready);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 0;
    end else if ($urandom_range(999) < p_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = rand_target();
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
    end
    drive_mem();
    @(negedge clk);
    #1;
    observe();
  endtask

  task automatic do_reset(input int n);
    step_edge();
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    mem_q.delete();
    exp_q.delete();
    model_pc    = RST_PC;
    model_stall = 0;
    pend        = 0;
    last_redir  = 0;
    repeat (n) step_edge();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_no_req", {31'b0, imem_req_valid}, 32'd0);
    step_edge();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    drive_mem();
    @(negedge clk);
    #1;
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    observe();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;

    do_reset(3);

    // Straight-line fetch from RESET_PC, wrapping through 0.
    lat_max = 1; p_ready = 100; p_iready = 100; p_redir = 0;
    repeat (12) cycle();

    // Decode stalled: only DEPTH requests may go out after the redirect.
    p_iready = 0;
    force_redir = 1; force_pc = 32'h0000_0200;
    cycle();
    hs_count = 0;
    repeat (12) cycle();
    check("bp_req_count",     hs_count, DEPTH);
    check("bp_req_valid_low", {31'b0, imem_req_valid}, 32'd0);
    p_iready = 100;
    repeat (10) cycle();

    // Redirect while requests are in flight with longer latency.
    lat_max = 3;
    repeat (6) cycle();
    force_redir = 1; force_pc = 32'h0000_0100;
    cycle();
    repeat (12) cycle();

    // Misaligned redirect target.
    force_redir = 1; force_pc = 32'h0000_0102;
    cycle();
    repeat (12) cycle();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("fault_entry_seen", exp_q.size(), 32'd0);
`endif
    force_redir = 1; force_pc = 32'h0000_0300;
    cycle();
    repeat (8) cycle();

    // Random traffic with a reset in the middle.
    p_ready = 70; p_iready = 70; p_redir = 30;
    repeat (1500) cycle();
    do_reset(2);
    p_ready = 70; p_iready = 70; p_redir = 30;
    repeat (800) cycle();

    // Stop issuing and drain: everything accepted must have been delivered.
    p_redir = 0; p_ready = 0; p_iready = 100;
    repeat (12) cycle();
    check("final_exp_empty",   exp_q.size(), 32'd0);
    check("final_instr_valid", {31'b0, instr_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
